// File: rtl/vault_phase_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module : vault_phase_sequencer
// Runs the puzzle phases strictly in order, with a per-phase timeout, a
// lockout penalty after each tolerated failure and a global retry budget.
// Rev    : 1.0
// ============================================================================
module vault_phase_sequencer #(
   parameter int NUM_PHASES     = 3,
   parameter int TIMEOUT_CYCLES = 1000,
   parameter int MAX_RETRIES    = 2,
   parameter int LOCKOUT_CYCLES = 500,
   parameter int PW             = (NUM_PHASES > 1) ? $clog2(NUM_PHASES) : 1
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic [NUM_PHASES-1:0] phase_done,
   input  logic [NUM_PHASES-1:0] phase_fail,
   output logic [NUM_PHASES-1:0] phase_en,
   output logic                  phase_clr,
   output logic [PW-1:0]         cur_phase,
   output logic                  busy,
   output logic                  vault_open,
   output logic                  locked,
   output logic                  alarm,
   output logic [3:0]            retries_left
);

   localparam int TMAX = (TIMEOUT_CYCLES > LOCKOUT_CYCLES) ? TIMEOUT_CYCLES : LOCKOUT_CYCLES;
   localparam int TW   = $clog2(TMAX + 1);

   localparam logic [TW-1:0] WAIT_LAST  = TW'(TIMEOUT_CYCLES - 1);
   localparam logic [TW-1:0] LOCK_LAST  = TW'(LOCKOUT_CYCLES - 1);
   localparam logic [PW-1:0] LAST_PHASE = PW'(NUM_PHASES - 1);
   localparam logic [3:0]    RETRY_INIT = 4'(MAX_RETRIES);

   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_CLEAR     = 3'd1,
      S_ARM       = 3'd2,
      S_WAIT      = 3'd3,
      S_EVAL_FAIL = 3'd4,
      S_LOCKOUT   = 3'd5,
      S_OPEN      = 3'd6,
      S_ALARM     = 3'd7
   } state_t;

   state_t                  state;
   state_t                  state_nx;
   logic [PW-1:0]           cur_phase_nx;
   logic [TW-1:0]           timer;
   logic [TW-1:0]           timer_nx;
   logic [TW-1:0]           timer_inc;
   logic [3:0]              retries_nx;
   logic [NUM_PHASES-1:0]   phase_en_nx;
   logic                    act_done;
   logic                    act_fail;

   // Only the active phase's status bits matter; all others are ignored.
   assign act_done  = phase_done[cur_phase];
   assign act_fail  = phase_fail[cur_phase];
   assign timer_inc = (&timer) ? timer : timer + TW'(1);

   always_comb begin
      state_nx     = state;
      cur_phase_nx = cur_phase;
      timer_nx     = timer;
      retries_nx   = retries_left;

      case (state)
         S_IDLE: begin
            if (start) begin
               state_nx     = S_CLEAR;
               cur_phase_nx = '0;
            end
         end
         S_CLEAR: begin
            timer_nx = '0;
            state_nx = S_ARM;
         end
         S_ARM: begin
            timer_nx = '0;
            state_nx = S_WAIT;
         end
         S_WAIT: begin
            timer_nx = timer_inc;
            // Fail beats done, and done beats a timeout on the same cycle.
            if (act_fail) begin
               state_nx = S_EVAL_FAIL;
            end else if (act_done) begin
               if (cur_phase == LAST_PHASE) begin
                  state_nx = S_OPEN;
               end else begin
                  cur_phase_nx = cur_phase + PW'(1);
                  state_nx     = S_CLEAR;
               end
            end else if (timer == WAIT_LAST) begin
               state_nx = S_EVAL_FAIL;
            end
         end
         S_EVAL_FAIL: begin
            if (retries_left == 4'd0) begin
               state_nx = S_ALARM;
            end else begin
               retries_nx = retries_left - 4'd1;
               timer_nx   = '0;
               state_nx   = S_LOCKOUT;
            end
         end
         S_LOCKOUT: begin
            timer_nx = timer_inc;
            if (timer == LOCK_LAST) begin
               cur_phase_nx = '0;
               state_nx     = S_CLEAR;
            end
         end
         S_OPEN:  state_nx = S_OPEN;
         S_ALARM: state_nx = S_ALARM;
         default: state_nx = S_IDLE;
      endcase

      phase_en_nx = '0;
      if (state_nx == S_WAIT) begin
         phase_en_nx = NUM_PHASES'(1) << cur_phase_nx;
      end
   end

   // Outputs are decoded from the next state so every output is a flop.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state        <= S_IDLE;
         cur_phase    <= '0;
         timer        <= '0;
         retries_left <= RETRY_INIT;
         phase_en     <= '0;
         phase_clr    <= 1'b0;
         busy         <= 1'b0;
         vault_open   <= 1'b0;
         locked       <= 1'b0;
         alarm        <= 1'b0;
      end else begin
         state        <= state_nx;
         cur_phase    <= cur_phase_nx;
         timer        <= timer_nx;
         retries_left <= retries_nx;
         phase_en     <= phase_en_nx;
         phase_clr    <= (state_nx == S_CLEAR);
         busy         <= !((state_nx == S_IDLE) || (state_nx == S_OPEN) || (state_nx == S_ALARM));
         vault_open   <= (state_nx == S_OPEN);
         locked       <= (state_nx == S_LOCKOUT);
         alarm        <= (state_nx == S_ALARM);
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_vault_phase_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module : tb_vault_phase_sequencer
// Self-checking bench: directed scenario table plus random scenarios, both
// compared cycle by cycle against a phase/attempt-level timeline model.
// Rev    : 1.0
// ============================================================================
module tb_vault_phase_sequencer;

   localparam int NP = 3;
   localparam int TO = 1000;
   localparam int MR = 2;
   localparam int LK = 500;

   localparam int K_DONE = 0;
   localparam int K_FAIL = 1;
   localparam int K_BOTH = 2;
   localparam int K_NONE = 3;

   logic          clk = 1'b0;
   logic          reset = 1'b0;
   logic          start = 1'b0;
   logic [NP-1:0] phase_done = '0;
   logic [NP-1:0] phase_fail = '0;
   logic [NP-1:0] phase_en;
   logic          phase_clr;
   logic [1:0]    cur_phase;
   logic          busy;
   logic          vault_open;
   logic          locked;
   logic          alarm;
   logic [3:0]    retries_left;

   vault_phase_sequencer #(
      .NUM_PHASES     (NP),
      .TIMEOUT_CYCLES (TO),
      .MAX_RETRIES    (MR),
      .LOCKOUT_CYCLES (LK)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .start        (start),
      .phase_done   (phase_done),
      .phase_fail   (phase_fail),
      .phase_en     (phase_en),
      .phase_clr    (phase_clr),
      .cur_phase    (cur_phase),
      .busy         (busy),
      .vault_open   (vault_open),
      .locked       (locked),
      .alarm        (alarm),
      .retries_left (retries_left)
   );

   always #5 clk = ~clk;

   // One response per enabled attempt: what the phase reports and on which
   // enabled cycle (1-based) it starts reporting it.
   typedef struct {
      int kind;
      int delay;
   } resp_t;

   typedef struct {
      logic [2:0] en;
      logic       clr;
      int         cur;
      logic       bsy;
      logic       opn;
      logic       lck;
      logic       alm;
      logic [3:0] ret;
      int         att;
      int         widx;
      bit         term;
   } exp_t;

   typedef struct {
      resp_t      r[6];
      bit         noise;
      bit         exp_open;
      bit         exp_alarm;
      logic [3:0] exp_ret;
      int         exp_len;
   } vec_t;

   resp_t resp[$];
   exp_t  trace[$];
   vec_t  tbl[7];

   int n_checks = 0;
   int n_fail   = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
      n_checks++;
      if (act !== expv) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, expv);
      end
   endtask

   function automatic resp_t mk(input int kind, input int delay);
      resp_t r;
      r.kind  = kind;
      r.delay = delay;
      return r;
   endfunction

   function automatic resp_t rand_resp();
      int sel;
      sel = int'($urandom_range(0, 99));
      if (sel < 60)      return mk(K_DONE, int'($urandom_range(1, 12)));
      else if (sel < 78) return mk(K_FAIL, int'($urandom_range(1, 12)));
      else if (sel < 88) return mk(K_BOTH, int'($urandom_range(1, 12)));
      else if (sel < 93) return mk(K_NONE, 1);
      else               return mk(K_DONE, TO + int'($urandom_range(0, 1)));
   endfunction

   function automatic logic [14:0] dut_vec();
      return {phase_en, phase_clr, cur_phase, busy, vault_open, locked, alarm, retries_left};
   endfunction

   function automatic logic [14:0] exp_vec(input exp_t e);
      return {e.en, e.clr, 2'(e.cur), e.bsy, e.opn, e.lck, e.alm, e.ret};
   endfunction

   function automatic void push(input logic [2:0] en, input logic clr, input int cur,
                                input logic bsy, input logic opn, input logic lck,
                                input logic alm, input int ret, input int att,
                                input int widx, input bit term);
      exp_t e;
      e.en = en; e.clr = clr; e.cur = cur; e.bsy = bsy; e.opn = opn;
      e.lck = lck; e.alm = alm; e.ret = 4'(ret); e.att = att; e.widx = widx; e.term = term;
      trace.push_back(e);
   endfunction

   // Timeline model: each attempt is clear, arm, then a run of enabled cycles;
   // the outcome decides between next phase, open, lockout+restart or alarm.
   task automatic build_trace();
      int    p   = 0;
      int    r   = MR;
      int    a   = 0;
      bit    fin = 1'b0;
      bit    seen;
      int    w;
      resp_t rr;
      trace.delete();
      while (!fin) begin
         if (a >= resp.size()) resp.push_back(rand_resp());
         rr = resp[a];
         push(3'b000, 1'b1, p, 1'b1, 1'b0, 1'b0, 1'b0, r, -1, 0, 1'b0);
         push(3'b000, 1'b0, p, 1'b1, 1'b0, 1'b0, 1'b0, r, -1, 0, 1'b0);
         seen = (rr.kind != K_NONE) && (rr.delay <= TO);
         w    = seen ? rr.delay : TO;
         for (int j = 1; j <= w; j++)
            push(3'(1 << p), 1'b0, p, 1'b1, 1'b0, 1'b0, 1'b0, r, a, j, 1'b0);
         if (seen && rr.kind == K_DONE) begin
            if (p == NP - 1) begin
               for (int k = 0; k < 4; k++)
                  push(3'b000, 1'b0, p, 1'b0, 1'b1, 1'b0, 1'b0, r, -1, 0, 1'b1);
               fin = 1'b1;
            end else begin
               p++;
            end
         end else begin
            push(3'b000, 1'b0, p, 1'b1, 1'b0, 1'b0, 1'b0, r, -1, 0, 1'b0);
            if (r == 0) begin
               for (int k = 0; k < 4; k++)
                  push(3'b000, 1'b0, p, 1'b0, 1'b0, 1'b0, 1'b1, r, -1, 0, 1'b1);
               fin = 1'b1;
            end else begin
               r--;
               for (int j = 0; j < LK; j++)
                  push(3'b000, 1'b0, p, 1'b1, 1'b0, 1'b1, 1'b0, r, -1, 0, 1'b0);
               p = 0;
            end
         end
         a++;
      end
   endtask

   // Called at a negedge; start is sampled on the next rising edge.
   task automatic run_scenario(input bit noise, input int limit, output int term_idx);
      exp_t        e;
      resp_t       rr;
      logic [2:0]  pd;
      logic [2:0]  pf;
      logic [2:0]  mask;
      logic [31:0] nz;
      int          n;
      term_idx = -1;
      n = (limit < trace.size()) ? limit : trace.size();
      start = 1'b1;
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         e = trace[i];
         chk($sformatf("trace[%0d]", i), 32'(dut_vec()), 32'(exp_vec(e)));
         if (term_idx < 0 && (vault_open || alarm)) term_idx = i;
         pd = '0;
         pf = '0;
         if (e.widx > 0) begin
            rr   = resp[e.att];
            mask = 3'(1 << e.cur);
            if (rr.kind != K_NONE && e.widx >= rr.delay) begin
               if (rr.kind == K_DONE || rr.kind == K_BOTH) pd = pd | mask;
               if (rr.kind == K_FAIL || rr.kind == K_BOTH) pf = pf | mask;
            end
            if (noise) begin
               nz = $urandom;
               pd = pd | (nz[2:0] & ~mask);
               pf = pf | (nz[5:3] & ~mask);
            end
         end
         phase_done = pd;
         phase_fail = pf;
         start = e.term ? 1'b1 : (noise ? 1'($urandom_range(0, 1)) : 1'b0);
      end
   endtask

   task automatic check_reset(input string name);
      chk(name, 32'(dut_vec()), 32'({3'b000, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 4'(MR)}));
   endtask

   // Called at a negedge: reset falls mid-cycle, outputs checked before the next edge.
   task automatic do_reset(input string name);
      reset = 1'b0;
      #1;
      check_reset(name);
      @(negedge clk);
      reset      = 1'b1;
      start      = 1'b0;
      phase_done = '0;
      phase_fail = '0;
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int t;

      for (int k = 0; k < 7; k++) begin
         for (int j = 0; j < 6; j++) tbl[k].r[j] = mk(K_DONE, 1);
         tbl[k].noise = 1'b0;
      end
      // A: done 5 cycles after each enable
      for (int j = 0; j < 3; j++) tbl[0].r[j] = mk(K_DONE, 6);
      tbl[0].exp_open = 1; tbl[0].exp_alarm = 0; tbl[0].exp_ret = 4'd2; tbl[0].exp_len = 24;
      // B: phase 1 fails, full restart succeeds
      tbl[1].r[0] = mk(K_DONE, 3); tbl[1].r[1] = mk(K_FAIL, 4);
      for (int j = 2; j < 5; j++) tbl[1].r[j] = mk(K_DONE, 2);
      tbl[1].exp_open = 1; tbl[1].exp_alarm = 0; tbl[1].exp_ret = 4'd1; tbl[1].exp_len = 524;
      // C: three consecutive failures exhaust the budget
      for (int j = 0; j < 3; j++) tbl[2].r[j] = mk(K_FAIL, 1);
      tbl[2].exp_open = 0; tbl[2].exp_alarm = 1; tbl[2].exp_ret = 4'd0; tbl[2].exp_len = 1012;
      // D: phase 0 never answers
      tbl[3].r[0] = mk(K_NONE, 1);
      tbl[3].exp_open = 1; tbl[3].exp_alarm = 0; tbl[3].exp_ret = 4'd1; tbl[3].exp_len = 1512;
      // E: done on the last allowed enabled cycle
      tbl[4].r[0] = mk(K_DONE, TO);
      tbl[4].exp_open = 1; tbl[4].exp_alarm = 0; tbl[4].exp_ret = 4'd2; tbl[4].exp_len = 1008;
      // F: done+fail together, with spurious bits on inactive phases
      tbl[5].r[0] = mk(K_BOTH, 2); tbl[5].noise = 1'b1;
      tbl[5].exp_open = 1; tbl[5].exp_alarm = 0; tbl[5].exp_ret = 4'd1; tbl[5].exp_len = 514;
      // G: failure on the last phase
      tbl[6].r[2] = mk(K_FAIL, 7);
      tbl[6].exp_open = 1; tbl[6].exp_alarm = 0; tbl[6].exp_ret = 4'd1; tbl[6].exp_len = 525;

      repeat (2) @(negedge clk);
      check_reset("reset_state");
      reset = 1'b1;
      for (int i = 0; i < 3; i++) begin
         phase_done = 3'($urandom);
         phase_fail = 3'($urandom);
         @(negedge clk);
         check_reset($sformatf("idle_hold[%0d]", i));
      end
      phase_done = '0;
      phase_fail = '0;

      for (int k = 0; k < 7; k++) begin
         resp.delete();
         for (int j = 0; j < 6; j++) resp.push_back(tbl[k].r[j]);
         build_trace();
         run_scenario(tbl[k].noise, 1 << 30, t);
         chk($sformatf("vec%0d_terminal_cycle", k), 32'(t), 32'(tbl[k].exp_len));
         chk($sformatf("vec%0d_vault_open", k), 32'(vault_open), 32'(tbl[k].exp_open));
         chk($sformatf("vec%0d_alarm", k), 32'(alarm), 32'(tbl[k].exp_alarm));
         chk($sformatf("vec%0d_retries_left", k), 32'(retries_left), 32'(tbl[k].exp_ret));
         do_reset($sformatf("vec%0d_reset", k));
      end

      for (int s = 0; s < 6; s++) begin
         resp.delete();
         build_trace();
         run_scenario(1'b1, 1 << 30, t);
         do_reset($sformatf("rand%0d_reset", s));
      end

      // Reset pulled while phase 2 is enabled (entry 10 is its third enabled cycle).
      resp.delete();
      resp.push_back(mk(K_DONE, 1));
      resp.push_back(mk(K_DONE, 1));
      resp.push_back(mk(K_DONE, 50));
      build_trace();
      run_scenario(1'b0, 11, t);
      chk("mid_wait_phase_en", 32'(phase_en), 32'(3'b100));
      do_reset("async_reset_mid_wait");

      resp.delete();
      for (int j = 0; j < 6; j++) resp.push_back(tbl[0].r[j]);
      build_trace();
      run_scenario(1'b0, 1 << 30, t);
      chk("after_reset_terminal_cycle", 32'(t), 32'(tbl[0].exp_len));
      chk("after_reset_vault_open", 32'(vault_open), 32'(1'b1));

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
